disp_control: RTL and testbench



---
 rtl/disp_control.sv | 87 ++++++++
 tb/tb_disp_control.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/disp_control.sv
// disp_control: 8x8 LED matrix controller.
// Holds an 8x8 frame buffer (one row written per cycle) and scans it onto a
// one-hot row drive plus column data, DWELL cycles per row.
// Optional Game-of-Life step engine compiled in when DISP_LIFE_EN is defined;
// without it the step input is ignored and the buffer changes only by writes.
// Handshake: none; we/step are single-cycle strobes sampled on every rising
// edge, reset has priority over step, and step has priority over we.

module disp_control #(
   parameter int unsigned DWELL = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [2:0] addr,
   input  logic [7:0] BitIn,
   input  logic       step,
   output logic [7:0] row,
   output logic [7:0] col
);

   localparam logic [15:0] LAST = 16'(DWELL - 1);

   logic [7:0]  fb [8];
   logic [2:0]  idx;
   logic [15:0] cnt;
   logic [2:0]  idx_nxt;

   assign idx_nxt = idx + 3'd1;

`ifdef DISP_LIFE_EN
   logic [7:0] life_nxt [8];

   // One Life cell per (r, c); neighbour rows/columns wrap around the torus.
   for (genvar r = 0; r < 8; r++) begin : g_row
      for (genvar c = 0; c < 8; c++) begin : g_col
         localparam int RU = (r + 7) % 8;
         localparam int RD = (r + 1) % 8;
         localparam int CL = (c + 7) % 8;
         localparam int CR = (c + 1) % 8;
         logic [3:0] n;
         assign n = 4'(fb[RU][CL]) + 4'(fb[RU][c]) + 4'(fb[RU][CR]) +
                    4'(fb[r][CL])                  + 4'(fb[r][CR])  +
                    4'(fb[RD][CL]) + 4'(fb[RD][c]) + 4'(fb[RD][CR]);
         assign life_nxt[r][c] = (n == 4'd3) | (fb[r][c] & (n == 4'd2));
      end
   end
`else
   // The step strobe has no effect in this build.
   logic unused_step;
   assign unused_step = step;
`endif

   // Frame buffer: reset clears, a Life step replaces the whole frame,
   // otherwise a write updates one row.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) fb[i] <= 8'h00;
`ifdef DISP_LIFE_EN
      end else if (step) begin
         for (int i = 0; i < 8; i++) fb[i] <= life_nxt[i];
`endif
      end else if (we) begin
         fb[addr] <= BitIn;
      end
   end

   // Row scan: dwell counter, row index and registered row/column drives.
   // col always samples the buffer as it stood before this edge's update.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx <= 3'd7;
         cnt <= LAST;
         row <= 8'h00;
         col <= 8'h00;
      end else if (cnt == LAST) begin
         cnt <= 16'd0;
         idx <= idx_nxt;
         row <= 8'h01 << idx_nxt;
         col <= fb[idx_nxt];
      end else begin
         cnt <= cnt + 16'd1;
         col <= fb[idx];
      end
   end

endmodule

// File: tb/tb_disp_control.sv
// tb_disp_control: directed bench for disp_control with DWELL=1 and DWELL=3
// instances sharing the same stimulus. Life checks follow DISP_LIFE_EN.

module tb_disp_control;

   logic       clk = 1'b0;
   logic       reset;
   logic       we;
   logic [2:0] addr;
   logic [7:0] bit_in;
   logic       step;
   logic [7:0] row1, col1, row3, col3;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_n  = 0;

   logic [7:0] frame  [8];
   logic [7:0] exp_fb [8];

   always #5 clk = ~clk;

   disp_control #(.DWELL(1)) dut1 (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .BitIn(bit_in),
      .step(step), .row(row1), .col(col1)
   );

   disp_control #(.DWELL(3)) dut3 (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .BitIn(bit_in),
      .step(step), .row(row3), .col(col3)
   );

   // Advance one rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_to(input int e);
      while (edge_n < e) tick();
   endtask

   // Two reset edges, then release; edge_n counts edges since release.
   task automatic do_reset();
      reset = 1'b1;
      we    = 1'b0;
      step  = 1'b0;
      tick();
      tick();
      chk("reset_row1", row1, 8'h00);
      chk("reset_col1", col1, 8'h00);
      chk("reset_row3", row3, 8'h00);
      chk("reset_col3", col3, 8'h00);
      reset  = 1'b0;
      edge_n = 0;
      tick();
      chk("first_row1", row1, 8'h01);
      chk("first_col1", col1, 8'h00);
      chk("first_row3", row3, 8'h01);
      chk("first_col3", col3, 8'h00);
   endtask

   task automatic write_row(input logic [2:0] a, input logic [7:0] d);
      we     = 1'b1;
      addr   = a;
      bit_in = d;
      tick();
      we     = 1'b0;
   endtask

   // DWELL=1 instance shows row (edge_n-1)%8 after each edge since release.
   task automatic scan_check(input int cycles);
      logic [7:0] one;
      one = 8'h01;
      for (int i = 0; i < cycles; i++) begin
         int r;
         r = (edge_n - 1) % 8;
         chk("scan_row", row1, one << r);
         chk("scan_col", col1, exp_fb[r]);
         tick();
      end
   endtask

   initial begin
      reset  = 1'b1;
      we     = 1'b0;
      addr   = 3'd0;
      bit_in = 8'h00;
      step   = 1'b0;
      frame[0] = 8'hE0; frame[1] = 8'h8A; frame[2] = 8'hEA; frame[3] = 8'h8E;
      frame[4] = 8'h00; frame[5] = 8'hEB; frame[6] = 8'h8C; frame[7] = 8'hEB;

      do_reset();

      // Frame load on edges 2..9, then one full frame of scan.
      for (int i = 0; i < 8; i++) write_row(3'(i), frame[i]);
      for (int i = 0; i < 8; i++) exp_fb[i] = frame[i];
      scan_check(8);

      // DWELL=3: row 6 up to edge 21, row 7 held on edges 22..24, wrap at 25.
      run_to(21);
      chk("dwell_row6", row3, 8'h40);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("dwell_row7", row3, 8'h80);
         chk("dwell_col7", col3, 8'hEB);
      end
      tick();
      chk("wrap_row0", row3, 8'h01);
      chk("wrap_col0", col3, 8'hE0);

      // Same-edge write on DWELL=3: row 2 becomes lit on edge 31.
      run_to(30);
      we = 1'b1; addr = 3'd2; bit_in = 8'h5A;
      tick();
      we = 1'b0;
      chk("same_edge_row3", row3, 8'h04);
      chk("same_edge_old3", col3, 8'hEA);
      chk("same_edge_row1", row1, 8'h40);
      chk("same_edge_col1", col1, 8'h8C);
      tick();
      chk("next_edge_row3", row3, 8'h04);
      chk("next_edge_new3", col3, 8'h5A);

      // Same-edge write on DWELL=1: row 2 lit on edge 35, again on 43.
      run_to(34);
      we = 1'b1; addr = 3'd2; bit_in = 8'h3C;
      tick();
      we = 1'b0;
      chk("same_edge_row1b", row1, 8'h04);
      chk("same_edge_old1", col1, 8'h5A);
      run_to(43);
      chk("next_frame_row1", row1, 8'h04);
      chk("next_frame_new1", col1, 8'h3C);

`ifdef DISP_LIFE_EN
      // Blinker: horizontal in row 3 turns vertical in column 3, then back.
      do_reset();
      write_row(3'd3, 8'h1C);
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) exp_fb[i] = 8'h00;
      exp_fb[2] = 8'h08; exp_fb[3] = 8'h08; exp_fb[4] = 8'h08;
      scan_check(8);
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) exp_fb[i] = 8'h00;
      exp_fb[3] = 8'h1C;
      scan_check(8);

      // Wrapped vertical blinker in column 0; the write on the step edge is dropped.
      do_reset();
      write_row(3'd7, 8'h01);
      write_row(3'd0, 8'h01);
      write_row(3'd1, 8'h01);
      step = 1'b1; we = 1'b1; addr = 3'd0; bit_in = 8'hFF;
      tick();
      step = 1'b0; we = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) exp_fb[i] = 8'h00;
      exp_fb[0] = 8'h83;
      scan_check(8);
`else
      // Without the Life engine a step pulse leaves the buffer untouched.
      do_reset();
      write_row(3'd3, 8'h1C);
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) exp_fb[i] = 8'h00;
      exp_fb[3] = 8'h1C;
      scan_check(8);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
